onchip_mem_arbiter: RTL and testbench
=====================================

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, word-address width of the shared RAM (2048 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 SHALL have port clk, input, 1, single clock for all logic.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port reset_req, input, 1, high requests a quiescent RAM (no new accesses, clock enable low).
REQ-006 SHALL have ports m0_address / m1_address, input, ADDR_W, requester word address.
REQ-007 SHALL have ports mN_byteenable, input, DATA_W/8; mN_writedata, input, DATA_W.
REQ-008 SHALL have ports mN_read and mN_write, input, 1 each; both high together is illegal; the bench flags it.
REQ-009 SHALL have ports mN_waitrequest, output, 1; mN_readdata, output, DATA_W; mN_readdatavalid, output, 1.
REQ-010 SHALL have memory-side outputs mem_address (ADDR_W), mem_byteenable, mem_writedata, mem_chipselect (1), mem_write (1), mem_clken (1).
REQ-011 SHALL have memory-side input mem_readdata, DATA_W; RAM read latency is exactly 1 clk (registered address, unregistered q).

Function
REQ-012 Requester N "requests" when mN_read | mN_write; at most one grant per cycle, combinational from current requests and last_grant register.
REQ-013 Arbitration SHALL be round-robin: with both requesting, grant goes to the requester not in last_grant; a single requester is granted immediately.
REQ-014 last_grant SHALL update only on a cycle with a grant.
REQ-015 Granted requester SHALL see waitrequest=0 that cycle; any non-granted requesting master SHALL see waitrequest=1 and hold its signals stable.
REQ-016 Memory outputs SHALL mux the granted requester's address/byteenable/writedata; mem_chipselect=1 on a grant; mem_write=granted write; all mem_* outputs 0 when no grant.
REQ-017 On a granted read, rd_pending<=1 and rd_owner<=N; the next cycle mN_readdatavalid=1 for owner only, mN_readdata=mem_readdata.
REQ-018 mN_readdata SHALL be driven to both masters; only readdatavalid qualifies it.
REQ-019 Back-to-back reads (alternating or same master) SHALL sustain one access per cycle with no bubbles.
REQ-020 FSM states RUN, QUIESCE: RUN->QUIESCE when reset_req=1; QUIESCE->RUN when reset_req=0 and rd_pending=0.
REQ-021 In QUIESCE: no grants, all waitrequest=1 for requesting masters, mem_clken=0 except during the cycle an outstanding read returns.
REQ-022 A read granted in the cycle before reset_req rises SHALL still return readdatavalid the following cycle.
REQ-023 In RUN mem_clken=1.
REQ-024 Write then read of the same address on consecutive grants SHALL return the new data.

Reset
REQ-025 On reset: state=RUN, last_grant=1 (so m0 wins first tie), rd_pending=0, rd_owner=0.
REQ-026 During reset: waitrequest=1 to both masters, readdatavalid=0, mem_chipselect=0, mem_write=0, mem_clken=0.
REQ-027 A read in flight when reset asserts SHALL be dropped; no readdatavalid after reset release.

Structure
REQ-028 Shared package onchip_mem_pkg SHALL hold ADDR_W/DATA_W defaults and the RUN/QUIESCE state enum.
REQ-029 One sub-module rr_arbiter2 (two-request round-robin, grant + last_grant register) is natural; datapath muxing remains in the top.

Verification
REQ-030 m0 write addr 0x005 data 0xDEADBEEF be=0xF, then m1 read 0x005 -> m1_readdatavalid one cycle after grant, data 0xDEADBEEF.
REQ-031 Both masters read continuously from reset -> grants m0,m1,m0,m1..., each waitrequest=0 every other cycle, one readdatavalid per cycle.
REQ-032 Write 0x11223344 to 0x7FF, byte write be=0x2 data 0x0000AA00 -> readback 0x1122AA44.
REQ-033 m0 read granted, reset_req rises next cycle -> m0_readdatavalid still asserted, then mem_clken=0, waitrequest=1 until reset_req falls.
REQ-034 Assert reset with read outstanding -> no readdatavalid; after release m0 wins first simultaneous request.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// Shared defaults and state encoding for the two-master on-chip RAM arbiter.
package onchip_mem_pkg;

  localparam int unsigned AddrWDefault = 11;
  localparam int unsigned DataWDefault = 32;

  typedef enum logic {
    StRun,
    StQuiesce
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter: combinational grant, registered last winner.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; 1 after reset so m0 wins the first tie.
  logic last_grant_q;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req[0] && (!req[1] || last_grant_q)) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (|grant) begin
      last_grant_q <= grant[1];
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM (1-cycle read latency) between two masters with
// round-robin arbitration and a reset_req-driven quiesce mode.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,

  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_read,
  input  logic                m0_write,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,

  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_read,
  input  logic                m1_write,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,

  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  state_e     state_q;
  logic       rd_pending_q;
  logic       rd_owner_q;
  logic [1:0] req;
  logic [1:0] grant;
  logic       arb_enable;
  logic       granted;
  logic       sel;
  logic       rd_grant;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  // No new access while reset_req is high, even before the state register follows.
  assign arb_enable = (state_q == StRun) && !reset_req && !reset;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .enable (arb_enable),
    .req    (req),
    .grant  (grant)
  );

  assign granted  = |grant;
  assign sel      = grant[1];
  assign rd_grant = granted && (sel ? m1_read : m0_read);

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (granted) begin
      mem_address    = sel ? m1_address    : m0_address;
      mem_byteenable = sel ? m1_byteenable : m0_byteenable;
      mem_writedata  = sel ? m1_writedata  : m0_writedata;
      mem_write      = sel ? m1_write      : m0_write;
    end
  end

  assign mem_chipselect = granted;
  // In quiesce the clock only stays on for a read that is still returning.
  assign mem_clken      = !reset && ((state_q == StRun) || rd_pending_q);

  assign m0_waitrequest   = !grant[0];
  assign m1_waitrequest   = !grant[1];
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pending_q && !rd_owner_q;
  assign m1_readdatavalid = rd_pending_q && rd_owner_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRun;
      rd_pending_q <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      rd_pending_q <= rd_grant;
      if (rd_grant) begin
        rd_owner_q <= sel;
      end
      unique case (state_q)
        StRun: begin
          if (reset_req) state_q <= StQuiesce;
        end
        StQuiesce: begin
          if (!reset_req && !rd_pending_q) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural 1-cycle-latency RAM.
module tb_onchip_mem_arbiter;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 32;

  logic          clk, reset, reset_req;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [3:0]    m0_byteenable, m1_byteenable, mem_byteenable;
  logic [DW-1:0] m0_writedata, m1_writedata, mem_writedata, mem_readdata;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          mem_chipselect, mem_write, mem_clken;

  int n_checks = 0;
  int n_fail   = 0;

  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .reset_req        (reset_req),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_writedata     (m0_writedata),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_writedata     (m1_writedata),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered address, unregistered q, byte-enabled writes.
  logic [DW-1:0] ram [2048];
  logic [AW-1:0] ram_addr_q;
  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = '0;
    ram_addr_q = '0;
  end
  always @(posedge clk) begin
    if (mem_clken) begin
      if (mem_chipselect && mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  always @(negedge clk) begin
    if ((m0_read && m0_write) || (m1_read && m1_write)) $error("illegal read+write request");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    {m0_read, m0_write, m1_read, m1_write} = 4'b0000;
    m0_address = '0; m1_address = '0;
    m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = '0; m1_byteenable = '0;
  endtask

  // exp = {wait0, wait1, valid0, valid1, chipselect, mem_write, clken}
  task automatic chk_ctl(input string tag, input logic [6:0] exp);
    chk({tag, " m0_waitrequest"},   {31'd0, m0_waitrequest},   {31'd0, exp[6]});
    chk({tag, " m1_waitrequest"},   {31'd0, m1_waitrequest},   {31'd0, exp[5]});
    chk({tag, " m0_readdatavalid"}, {31'd0, m0_readdatavalid}, {31'd0, exp[4]});
    chk({tag, " m1_readdatavalid"}, {31'd0, m1_readdatavalid}, {31'd0, exp[3]});
    chk({tag, " mem_chipselect"},   {31'd0, mem_chipselect},   {31'd0, exp[2]});
    chk({tag, " mem_write"},        {31'd0, mem_write},        {31'd0, exp[1]});
    chk({tag, " mem_clken"},        {31'd0, mem_clken},        {31'd0, exp[0]});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  ctl;  // {r0, w0, r1, w1}
    logic [10:0] a0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic [10:0] a1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic [6:0]  exp;
    logic [31:0] erd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    string tag;
    logic [10:0] ea;
    logic [31:0] ewd;
    logic [3:0]  ebe;

    vecs[0]  = '{4'b0100, 11'h005, 32'hDEADBEEF, 4'hF, 11'h000, 32'h0, 4'h0, 7'b0100111, 32'h0};
    vecs[1]  = '{4'b0010, 11'h000, 32'h0, 4'h0, 11'h005, 32'h0, 4'hF, 7'b1000101, 32'h0};
    vecs[2]  = '{4'b0000, 11'h000, 32'h0, 4'h0, 11'h000, 32'h0, 4'h0, 7'b1101001, 32'hDEADBEEF};
    vecs[3]  = '{4'b0100, 11'h7FF, 32'h11223344, 4'hF, 11'h000, 32'h0, 4'h0, 7'b0100111, 32'h0};
    vecs[4]  = '{4'b0100, 11'h7FF, 32'h0000AA00, 4'h2, 11'h000, 32'h0, 4'h0, 7'b0100111, 32'h0};
    vecs[5]  = '{4'b1000, 11'h7FF, 32'h0, 4'hF, 11'h000, 32'h0, 4'h0, 7'b0100101, 32'h0};
    vecs[6]  = '{4'b0000, 11'h000, 32'h0, 4'h0, 11'h000, 32'h0, 4'h0, 7'b1110001, 32'h1122AA44};
    vecs[7]  = '{4'b1010, 11'h005, 32'h0, 4'hF, 11'h7FF, 32'h0, 4'hF, 7'b1000101, 32'h0};
    vecs[8]  = '{4'b1010, 11'h005, 32'h0, 4'hF, 11'h005, 32'h0, 4'hF, 7'b0101101, 32'h1122AA44};
    vecs[9]  = '{4'b1010, 11'h005, 32'h0, 4'hF, 11'h005, 32'h0, 4'hF, 7'b1010101, 32'hDEADBEEF};
    vecs[10] = '{4'b0000, 11'h000, 32'h0, 4'h0, 11'h000, 32'h0, 4'h0, 7'b1101001, 32'hDEADBEEF};

    // Reset held with requests pending: everything must stay quiet.
    reset = 1'b1; reset_req = 1'b0;
    idle_inputs();
    m0_read = 1'b1; m1_write = 1'b1; m1_address = 11'h3;
    #3;
    chk_ctl("reset", 7'b1100000);
    next_cycle();
    reset = 1'b0;

    // Table: write/readback, byte write, round-robin ties.
    for (int i = 0; i < 11; i++) begin
      {m0_read, m0_write, m1_read, m1_write} = vecs[i].ctl;
      m0_address = vecs[i].a0; m0_writedata = vecs[i].wd0; m0_byteenable = vecs[i].be0;
      m1_address = vecs[i].a1; m1_writedata = vecs[i].wd1; m1_byteenable = vecs[i].be1;
      #4;
      tag = $sformatf("vec%0d", i);
      chk_ctl(tag, vecs[i].exp);
      if (vecs[i].exp[4] || vecs[i].exp[3])
        chk({tag, " readdata"}, vecs[i].exp[4] ? m0_readdata : m1_readdata, vecs[i].erd);
      if (vecs[i].exp[2]) begin
        ea  = !vecs[i].exp[6] ? vecs[i].a0  : vecs[i].a1;
        ewd = !vecs[i].exp[6] ? vecs[i].wd0 : vecs[i].wd1;
        ebe = !vecs[i].exp[6] ? vecs[i].be0 : vecs[i].be1;
        chk({tag, " mem_address"}, {21'd0, mem_address}, {21'd0, ea});
        chk({tag, " mem_byteenable"}, {28'd0, mem_byteenable}, {28'd0, ebe});
        if (vecs[i].exp[1]) chk({tag, " mem_writedata"}, mem_writedata, ewd);
      end
      next_cycle();
    end

    // Both masters read continuously from reset: strict alternation, no bubbles.
    reset = 1'b1; idle_inputs();
    next_cycle();
    reset = 1'b0;
    m0_read = 1'b1; m0_address = 11'h005;
    m1_read = 1'b1; m1_address = 11'h7FF;
    for (int k = 0; k < 7; k++) begin
      if (k == 6) idle_inputs();
      #4;
      tag = $sformatf("stream%0d", k);
      if (k < 6) begin
        chk({tag, " m0_waitrequest"}, {31'd0, m0_waitrequest}, (k % 2 == 1) ? 32'd1 : 32'd0);
        chk({tag, " m1_waitrequest"}, {31'd0, m1_waitrequest}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      chk({tag, " m0_readdatavalid"}, {31'd0, m0_readdatavalid},
          (k > 0 && k % 2 == 1) ? 32'd1 : 32'd0);
      chk({tag, " m1_readdatavalid"}, {31'd0, m1_readdatavalid},
          (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
      if (k > 0)
        chk({tag, " readdata"}, m0_readdata, (k % 2 == 1) ? 32'hDEADBEEF : 32'h1122AA44);
      next_cycle();
    end

    // Read granted, then reset_req rises: data still returns, then quiesce.
    m0_read = 1'b1; m0_address = 11'h005;
    #4; chk_ctl("rq_grant", 7'b0100101);
    next_cycle();
    reset_req = 1'b1;
    m1_read = 1'b1; m1_address = 11'h7FF;
    #4; chk_ctl("rq_return", 7'b1110001);
    chk("rq_return readdata", m0_readdata, 32'hDEADBEEF);
    next_cycle();
    #4; chk_ctl("rq_quiesce0", 7'b1100000);
    next_cycle();
    #4; chk_ctl("rq_quiesce1", 7'b1100000);
    next_cycle();
    reset_req = 1'b0;
    #4; chk_ctl("rq_release", 7'b1100000);
    next_cycle();
    // m0 won last, so m1 takes the tie on resumption.
    #4; chk_ctl("rq_resume", 7'b1000101);
    next_cycle();
    idle_inputs();
    #4; chk_ctl("rq_resume_data", 7'b1101001);
    chk("rq_resume readdata", m1_readdata, 32'h1122AA44);
    next_cycle();

    // Reset with a read in flight: the read is dropped; m0 wins first tie afterwards.
    m0_read = 1'b1; m0_address = 11'h005;
    #4; chk_ctl("rst_grant", 7'b0100101);
    next_cycle();
    reset = 1'b1;
    m1_read = 1'b1; m1_address = 11'h7FF;
    #4; chk_ctl("rst_inflight", 7'b1100000);
    next_cycle();
    reset = 1'b0;
    #4; chk_ctl("rst_release", 7'b0100101);
    next_cycle();
    idle_inputs();
    #4; chk_ctl("rst_after", 7'b1110001);
    chk("rst_after readdata", m0_readdata, 32'hDEADBEEF);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
